// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and instruction memory (slave).
// The master issues the request and address; the slave returns a same-cycle ack and data word.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register, instruction fetch FSM (RESET -> FETCH -> EXEC) and next-PC selection.
// Also keeps a free-running count of retired instructions.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.master imem,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [15:0]     imm16,
  input  logic [31:0]     ext_imm,
  input  logic            advance,
  input  logic            branch_taken,
  input  logic            jump,
  output logic [31:0]     pc,
  output logic [31:0]     pc_plus4,
  output logic [31:0]     retired
);

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] next_pc;
  logic        fetch_done;
  logic        exec_done;

  assign pc_plus4       = pc + 32'd4;
  assign imem.imem_addr = pc;
  assign imm16          = instr[15:0];
  assign fetch_done     = (state == FETCH) && imem.imem_ack;
  assign exec_done      = (state == EXEC) && advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET;
    end else begin
      state <= next_state;
    end
  end

  // Request and valid are pure functions of state, so they never glitch with the inputs.
  always_comb begin
    next_state    = state;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    unique case (state)
      RESET: begin
        next_state = FETCH;
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (advance) begin
          next_state = FETCH;
        end
      end
      default: begin
        next_state = RESET;
      end
    endcase
  end

  // Jump beats branch; all sums wrap modulo 2^32.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + (ext_imm << 2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      instr   <= 32'h0000_0000;
      retired <= 32'h0000_0000;
    end else begin
      if (fetch_done) begin
        instr <= imem.imem_data;
      end
      if (exec_done) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit: stimulus pushes expected fetch addresses and
// instructions, a negedge monitor pops and compares them as the DUT presents fetches and executes.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] imm16;
  logic [31:0] ext_imm;
  logic        advance;
  logic        branch_taken;
  logic        jump;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;

  logic        wideMode = 1'b0;
  logic [31:0] wideExt  = 32'h0;

  int compared = 0;
  int errors   = 0;

  logic [31:0] fetchQ[$];
  logic [31:0] instrQ[$];
  logic [31:0] retQ[$];
  int          delayQ[$];

  logic [31:0] modelPc;
  logic [31:0] modelRetired;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .imm16        (imm16),
    .ext_imm      (ext_imm),
    .advance      (advance),
    .branch_taken (branch_taken),
    .jump         (jump),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  // Sign-extension stage; wideMode lets one step reach the upper address space.
  assign ext_imm = wideMode ? wideExt : 32'($signed(imm16));

  function automatic logic [31:0] extOf(input logic [31:0] word);
    return wideMode ? wideExt : 32'($signed(word[15:0]));
  endfunction

  function automatic logic [31:0] refNext(input logic [31:0] cur, input logic [31:0] word,
                                          input logic br, input logic jp, input logic [31:0] ext);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    if (br) return seq + ext * 32'd4;
    return seq;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_async_pc", pc, RESET_PC);
    checkOutput("rst_async_valid", {31'b0, instr_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    advance      = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    @(negedge clk);
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_addr", bus.imem_addr, RESET_PC);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_req", {31'b0, bus.imem_req}, 32'd0);
    checkOutput("rst_retired", retired, 32'd0);
    fetchQ.delete();
    instrQ.delete();
    retQ.delete();
    delayQ.delete();
    modelPc      = RESET_PC;
    modelRetired = 32'd0;
    fetchQ.push_back(RESET_PC);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_state_req", {31'b0, bus.imem_req}, 32'd0);
    checkOutput("reset_state_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    checkOutput("first_req", {31'b0, bus.imem_req}, 32'd1);
  endtask

  task automatic waitReq(output bit ok);
    int guard = 0;
    while (!bus.imem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = bus.imem_req;
    if (!ok) begin
      compared++;
      errors++;
      $display("[TB] FAIL req_timeout: imem_req %b after %0d cycles, required 1", bus.imem_req, guard);
    end
  endtask

  // One instruction: fetch with ackDelay wait states, then execute for advDelay extra cycles.
  task automatic applyStimulus(input int ackDelay, input int advDelay, input logic [31:0] word,
                               input logic br, input logic jp);
    bit ok;
    logic [31:0] nxt;
    waitReq(ok);
    if (!ok) return;
    for (int i = 0; i < ackDelay; i++) begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = $urandom;
      advance       = 1'($urandom_range(0, 1));
      branch_taken  = 1'($urandom_range(0, 1));
      jump          = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = word;
    advance       = 1'($urandom_range(0, 1));
    instrQ.push_back(word);
    retQ.push_back(modelRetired);
    delayQ.push_back(ackDelay + 1);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    advance      = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    for (int i = 0; i < advDelay; i++) begin
      bus.imem_ack  = 1'($urandom_range(0, 1));
      bus.imem_data = $urandom;
      branch_taken  = 1'($urandom_range(0, 1));
      jump          = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    nxt = refNext(modelPc, word, br, jp, extOf(word));
    fetchQ.push_back(nxt);
    modelPc      = nxt;
    modelRetired = modelRetired + 32'd1;
    advance       = 1'b1;
    branch_taken  = br;
    jump          = jp;
    bus.imem_ack  = 1'($urandom_range(0, 1));
    bus.imem_data = $urandom;
    @(negedge clk);
    advance      = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    bus.imem_ack = 1'b0;
  endtask

  // Monitor: pops expectations when a fetch starts or an instruction enters execution.
  logic [31:0] curAddr      = 32'h0;
  logic [31:0] expLastInstr = 32'h0;
  logic        prevReq      = 1'b0;
  logic        prevValid    = 1'b0;
  int          reqCycles    = 0;

  always @(negedge clk) begin
    if (rst) begin
      prevReq      = 1'b0;
      prevValid    = 1'b0;
      expLastInstr = 32'h0;
      reqCycles    = 0;
    end else begin
      checkOutput("req_and_valid", {31'b0, bus.imem_req & instr_valid}, 32'd0);
      if (bus.imem_req) begin
        if (!prevReq) begin
          reqCycles = 0;
          if (fetchQ.size() == 0) begin
            compared++;
            errors++;
            $display("[TB] FAIL unexpected_fetch: got fetch at %h, required none pending", bus.imem_addr);
            curAddr = bus.imem_addr;
          end else begin
            curAddr = fetchQ.pop_front();
          end
        end
        reqCycles++;
        checkOutput("fetch_addr", bus.imem_addr, curAddr);
        checkOutput("pc_plus4", pc_plus4, curAddr + 32'd4);
        checkOutput("instr_hold_fetch", instr, expLastInstr);
      end
      if (instr_valid) begin
        if (!prevValid) begin
          if (instrQ.size() == 0) begin
            compared++;
            errors++;
            $display("[TB] FAIL unexpected_exec: got instr %h, required no execution", instr);
          end else begin
            expLastInstr = instrQ.pop_front();
            checkOutput("retired", retired, retQ.pop_front());
            checkOutput("fetch_cycles", reqCycles, delayQ.pop_front());
          end
        end
        checkOutput("instr", instr, expLastInstr);
        checkOutput("imm16", {16'b0, imm16}, {16'b0, expLastInstr[15:0]});
        checkOutput("exec_pc", pc, curAddr);
      end
      prevReq   = bus.imem_req;
      prevValid = instr_valid;
    end
  end

  initial begin
    bit ok;
    logic [31:0] w;
    rst           = 1'b1;
    advance       = 1'b0;
    branch_taken  = 1'b0;
    jump          = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'h0;
    modelPc       = RESET_PC;
    modelRetired  = 32'd0;
    doReset();

    // Sequential fetches 0x0, 0x4, 0x8, then a jump to 0x100.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, $urandom, 1'b0, 1'b0);
    applyStimulus(0, 0, 32'hFC00_0040, 1'b0, 1'b1);
    // Backward branch from 0x100 to 0x0FC, with a five-cycle ack delay.
    applyStimulus(5, 1, 32'h1234_FFFE, 1'b1, 1'b0);
    wideMode = 1'b1;
    wideExt  = 32'h0FFF_FFC4;
    applyStimulus(1, 2, 32'h8765_4321, 1'b1, 1'b0);
    wideMode = 1'b0;
    // At 0x4000_0010 jump and branch together: jump must win.
    applyStimulus(0, 0, {6'h2A, 26'h000_0040}, 1'b1, 1'b1);

    for (int n = 0; n < 150; n++) begin
      applyStimulus($urandom_range(0, 4), $urandom_range(0, 3), $urandom,
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
    end

    // Reset while an ack is being presented in FETCH: the fetch is lost.
    waitReq(ok);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'hCAFE_F00D;
    #2;
    doReset();

    // Branch from 0x0 to 0xFFFF_FFFC, then wrap back to 0x0.
    applyStimulus(0, 0, 32'h0000_FFFE, 1'b1, 1'b0);
    applyStimulus(2, 0, $urandom, 1'b0, 1'b0);
    applyStimulus(0, 0, $urandom, 1'b0, 1'b0);

    // Reset while advance is high in EXEC: the advance is lost.
    waitReq(ok);
    w = $urandom;
    instrQ.push_back(w);
    retQ.push_back(modelRetired);
    delayQ.push_back(1);
    bus.imem_ack  = 1'b1;
    bus.imem_data = w;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    advance      = 1'b1;
    jump         = 1'b1;
    #2;
    doReset();

    for (int n = 0; n < 20; n++) begin
      applyStimulus($urandom_range(0, 2), $urandom_range(0, 2), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    checkOutput("fetchq_drained", fetchQ.size(), 32'd0);
    checkOutput("instrq_drained", instrQ.size(), 32'd0);
    checkOutput("final_retired", retired, modelRetired);
    checkOutput("final_pc", pc, modelPc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the word-aligned PC loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch byte address; equals pc.
REQ-006 imem_ack  input  1  memory response strobe; imem_data valid in the same cycle.
REQ-007 imem_data  input  32  instruction word returned by memory.
REQ-008 instr  output  32  latched instruction register.
REQ-009 instr_valid  output  1  high while instr holds an instruction awaiting execution.
REQ-010 imm16  output  16  instr[15:0], driven to the sign-extension stage.
REQ-011 ext_imm  input  32  sign-extended immediate returned by the sign-extension stage (combinational from imm16).
REQ-012 advance  input  1  core has finished the current instruction; PC update permitted.
REQ-013 branch_taken  input  1  current instruction is a taken branch.
REQ-014 jump  input  1  current instruction is a J-type jump.
REQ-015 pc  output  32  address of the current or in-flight instruction.
REQ-016 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-017 retired  output  32  count of instructions retired.

Function
REQ-018 The block SHALL implement a three-state FSM: RESET, FETCH, EXEC.
REQ-019 RESET SHALL last exactly one cycle after rst deasserts, drive imem_req=0, then go to FETCH.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; the state SHALL be held until imem_ack=1.
REQ-021 On imem_ack=1 in FETCH, instr SHALL load imem_data and the FSM SHALL go to EXEC on the next edge; imem_req SHALL be 0 from that edge on.
REQ-022 imem_ack outside FETCH SHALL be ignored (no instr update, no state change).
REQ-023 In EXEC, instr_valid SHALL be 1 and imm16 SHALL equal instr[15:0]; in all other states, instr_valid SHALL be 0.
REQ-024 advance, branch_taken and jump SHALL be sampled only in EXEC; outside EXEC they SHALL be ignored.
REQ-025 On advance=1 in EXEC, the FSM SHALL go to FETCH, retired SHALL increment by 1 (wrapping at 2^32), and pc SHALL load the next-PC.
REQ-026 Next-PC priority: jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch_taken -> pc_plus4 + (ext_imm << 2); else pc_plus4.
REQ-027 All next-PC arithmetic SHALL be 32-bit unsigned modulo 2^32; overflow wraps silently.
REQ-028 If jump and branch_taken are both 1, jump SHALL win.
REQ-029 Fetch-to-fetch minimum latency SHALL be 2 cycles: 1 cycle in FETCH with immediate ack, 1 cycle in EXEC with immediate advance.
REQ-030 pc_plus4 SHALL be combinational from pc at all times.

Reset
REQ-031 While rst=1, regardless of clk: state=RESET, pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, retired=0.
REQ-032 Reset asserted mid-fetch or mid-EXEC SHALL abort immediately; a pending ack or advance in that cycle SHALL be lost.
REQ-033 After rst deasserts, the first imem_req SHALL appear on the second rising edge, at address RESET_PC.

Verification
REQ-034 Reset, ack immediate -> imem_addr=0x0 first, then 0x4, then 0x8 across three advances; retired=3.
REQ-035 Ack delayed by 5 cycles -> imem_req stays 1 for 6 cycles, with imem_addr stable; instr updates only on the ack cycle.
REQ-036 pc=0x100, instr imm=0xFFFE, ext_imm=0xFFFF_FFFE, branch_taken=1, advance=1 -> next pc=0x0FC.
REQ-037 pc=0x4000_0010, instr[25:0]=0x0000040, jump=1, branch_taken=1 -> next pc=0x4000_0100.
REQ-038 pc=0xFFFF_FFFC, advance=1, no branch or jump -> pc wraps to 0x0; retired preset to 0xFFFF_FFFF wraps to 0.
REQ-039 rst pulsed while in FETCH with imem_ack=1 in the same cycle -> instr=0, pc=RESET_PC, instr_valid=0, with no EXEC entered.
